// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the 24-source internal bus with a per-owner hold limit.
// All outputs are registered; req reaches them only through the state registers.
module bus_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [23:0] req,
    output logic [4:0]  Select,
    output logic [23:0] grant,
    output logic        bus_valid,
    output logic        preempt
);

    typedef enum logic {IDLE, OWNED} state_t;

    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD - 1);

    state_t      state_q, state_d;
    logic [4:0]  owner_q, owner_d;
    logic [4:0]  ptr_q, ptr_d;
    logic [3:0]  hold_q, hold_d;
    logic [23:0] grant_q, grant_d;
    logic        preempt_q, preempt_d;

    logic [23:0] others;
    logic        own_req;
    logic [4:0]  win_all, win_oth;

    // First set bit at or after p, scanning upward and wrapping 23 -> 0.
    function automatic logic [4:0] rr_pick(input logic [23:0] v, input logic [4:0] p);
        logic [4:0] win;
        logic       found;
        logic [5:0] s;
        win   = 5'd0;
        found = 1'b0;
        for (int k = 0; k < 24; k++) begin
            s = {1'b0, p} + 6'(k);
            if (s >= 6'd24) s = s - 6'd24;
            if (!found && v[s[4:0]]) begin
                win   = s[4:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic logic [4:0] next_ptr(input logic [4:0] w);
        return (w == 5'd23) ? 5'd0 : w + 5'd1;
    endfunction

    assign others  = req & ~(24'd1 << owner_q);
    assign own_req = req[owner_q];
    assign win_all = rr_pick(req, ptr_q);
    assign win_oth = rr_pick(others, ptr_q);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = OWNED;
                    owner_d = win_all;
                    ptr_d   = next_ptr(win_all);
                    hold_d  = 4'd0;
                end
            end
            OWNED: begin
                if (own_req) begin
                    // Hold count also saturates while the owner is uncontested.
                    if (hold_q < HOLD_LIM) begin
                        hold_d = hold_q + 4'd1;
                    end else if (|others) begin
                        owner_d   = win_oth;
                        ptr_d     = next_ptr(win_oth);
                        hold_d    = 4'd0;
                        preempt_d = 1'b1;
                    end
                end else if (|others) begin
                    owner_d = win_oth;
                    ptr_d   = next_ptr(win_oth);
                    hold_d  = 4'd0;
                end else begin
                    state_d = IDLE;
                    owner_d = 5'd0;
                    hold_d  = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = 5'd0;
                hold_d  = 4'd0;
            end
        endcase
        grant_d = (state_d == OWNED) ? (24'd1 << owner_d) : 24'd0;
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q   <= IDLE;
            owner_q   <= 5'd0;
            ptr_q     <= 5'd0;
            hold_q    <= 4'd0;
            grant_q   <= 24'd0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            preempt_q <= preempt_d;
        end
    end

    assign Select    = owner_q;
    assign grant     = grant_q;
    assign bus_valid = (state_q == OWNED);
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench: two arbiters (MAX_HOLD=4 and MAX_HOLD=1) share req/clear
// and are compared against an integer-level round-robin model.
module tb_bus_arbiter;

    logic        clock;
    logic        clear;
    logic [23:0] req;
    logic [4:0]  sel_w   [2];
    logic [23:0] grant_w [2];
    logic        valid_w [2];
    logic        pre_w   [2];

    int n_checks;
    int n_errors;

    // Model state: owner (-1 = idle), pointer, hold count, preempt pulse.
    int m_own  [2];
    int m_ptr  [2];
    int m_hold [2];
    bit m_pre  [2];
    int m_max  [2];

    bus_arbiter #(.MAX_HOLD(4)) dut4 (
        .clock(clock), .clear(clear), .req(req),
        .Select(sel_w[0]), .grant(grant_w[0]), .bus_valid(valid_w[0]), .preempt(pre_w[0])
    );

    bus_arbiter #(.MAX_HOLD(1)) dut1 (
        .clock(clock), .clear(clear), .req(req),
        .Select(sel_w[1]), .grant(grant_w[1]), .bus_valid(valid_w[1]), .preempt(pre_w[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int rr(input logic [23:0] v, input int p);
        for (int k = 0; k < 24; k++) begin
            if (v[(p + k) % 24]) return (p + k) % 24;
        end
        return -1;
    endfunction

    function automatic void model_step(input logic [23:0] r, input logic c);
        logic [23:0] oth;
        int w;
        for (int k = 0; k < 2; k++) begin
            m_pre[k] = 1'b0;
            if (!c) begin
                m_own[k]  = -1;
                m_ptr[k]  = 0;
                m_hold[k] = 0;
            end else if (m_own[k] < 0) begin
                if (r != 24'd0) begin
                    w = rr(r, m_ptr[k]);
                    m_own[k]  = w;
                    m_ptr[k]  = (w + 1) % 24;
                    m_hold[k] = 0;
                end
            end else begin
                oth = r;
                oth[m_own[k]] = 1'b0;
                if (r[m_own[k]]) begin
                    if (m_hold[k] < m_max[k] - 1) begin
                        m_hold[k]++;
                    end else if (oth != 24'd0) begin
                        w = rr(oth, m_ptr[k]);
                        m_own[k]  = w;
                        m_ptr[k]  = (w + 1) % 24;
                        m_hold[k] = 0;
                        m_pre[k]  = 1'b1;
                    end
                end else if (oth != 24'd0) begin
                    w = rr(oth, m_ptr[k]);
                    m_own[k]  = w;
                    m_ptr[k]  = (w + 1) % 24;
                    m_hold[k] = 0;
                end else begin
                    m_own[k]  = -1;
                    m_hold[k] = 0;
                end
            end
        end
    endfunction

    // Apply inputs for one rising edge, advance the model, sample 1 ns later.
    task automatic step(input logic [23:0] r, input logic c);
        req   = r;
        clear = c;
        @(posedge clock);
        model_step(r, c);
        #1;
    endtask

    task automatic test_reset();
        step(24'hFFFFFF, 1'b0);
        step(24'hFFFFFF, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (sel_w[k] !== 5'd0 || grant_w[k] !== 24'd0 || valid_w[k] !== 1'b0 || pre_w[k] !== 1'b0) begin
                n_errors++;
                $display("FAIL reset dut%0d: sel=%0d grant=%h valid=%b pre=%b, required all zero",
                         k, sel_w[k], grant_w[k], valid_w[k], pre_w[k]);
            end
        end
    endtask

    task automatic test_basic();
        step(24'd0, 1'b0);
        step(24'h000001, 1'b1);
        n_checks++;
        if (grant_w[0] !== 24'h000001 || sel_w[0] !== 5'd0 || valid_w[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_grant: grant=%h sel=%0d valid=%b, required 000001/0/1",
                     grant_w[0], sel_w[0], valid_w[0]);
        end
        step(24'd0, 1'b1);
        n_checks++;
        if (grant_w[0] !== 24'd0 || valid_w[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_release: grant=%h valid=%b, required 0/0", grant_w[0], valid_w[0]);
        end
    endtask

    task automatic test_hold_preempt();
        logic [4:0] e4, e1;
        logic       p4, p1;
        step(24'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step((24'd1 << 20) | (24'd1 << 21), 1'b1);
            e4 = ((i / 4) % 2 == 0) ? 5'd20 : 5'd21;
            p4 = (i > 0) && (i % 4 == 0);
            e1 = (i % 2 == 0) ? 5'd20 : 5'd21;
            p1 = (i > 0);
            n_checks++;
            if (sel_w[0] !== e4 || pre_w[0] !== p4 || grant_w[0] !== (24'd1 << e4)) begin
                n_errors++;
                $display("FAIL hold4 cycle %0d: sel=%0d pre=%b, required sel=%0d pre=%b",
                         i, sel_w[0], pre_w[0], e4, p4);
            end
            n_checks++;
            if (sel_w[1] !== e1 || pre_w[1] !== p1) begin
                n_errors++;
                $display("FAIL hold1 cycle %0d: sel=%0d pre=%b, required sel=%0d pre=%b",
                         i, sel_w[1], pre_w[1], e1, p1);
            end
        end
    endtask

    task automatic test_wrap();
        step(24'd0, 1'b0);
        step(24'd1 << 23, 1'b1);
        step((24'd1 << 23) | 24'd1, 1'b1);
        n_checks++;
        if (sel_w[0] !== 5'd23 || valid_w[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_owner23: sel=%0d valid=%b, required 23/1", sel_w[0], valid_w[0]);
        end
        step(24'd1, 1'b1);
        n_checks++;
        if (sel_w[0] !== 5'd0 || valid_w[0] !== 1'b1 || pre_w[0] !== 1'b0 || grant_w[0] !== 24'd1) begin
            n_errors++;
            $display("FAIL wrap_handover: sel=%0d valid=%b pre=%b, required 0/1/0",
                     sel_w[0], valid_w[0], pre_w[0]);
        end
    endtask

    task automatic test_all_max1();
        logic [4:0] e;
        step(24'd0, 1'b0);
        for (int i = 0; i < 25; i++) begin
            step(24'hFFFFFF, 1'b1);
            e = 5'(i % 24);
            n_checks++;
            if (sel_w[1] !== e || grant_w[1] !== (24'd1 << e) || !$onehot(grant_w[1]) || valid_w[1] !== 1'b1) begin
                n_errors++;
                $display("FAIL sweep cycle %0d: sel=%0d grant=%h, required sel=%0d", i, sel_w[1], grant_w[1], e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] r2;
        r2 = (24'd1 << 19) | (24'd1 << 21) | (24'd1 << 3);
        step(24'd0, 1'b0);
        step(24'd1 << 19, 1'b1);
        step(r2, 1'b1);
        n_checks++;
        if (sel_w[0] !== 5'd19 || valid_w[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL midreset_owner: sel=%0d valid=%b, required 19/1", sel_w[0], valid_w[0]);
        end
        step(r2, 1'b0);
        n_checks++;
        if (sel_w[0] !== 5'd0 || grant_w[0] !== 24'd0 || valid_w[0] !== 1'b0 || pre_w[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_clear: sel=%0d grant=%h valid=%b pre=%b, required all zero",
                     sel_w[0], grant_w[0], valid_w[0], pre_w[0]);
        end
        step(r2, 1'b1);
        n_checks++;
        if (sel_w[0] !== 5'd3 || valid_w[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL midreset_rearb: sel=%0d valid=%b, required 3/1", sel_w[0], valid_w[0]);
        end
    endtask

    task automatic test_random();
        logic [23:0] r;
        logic [23:0] eg;
        logic        c;
        int          ch;
        r = 24'd0;
        step(24'd0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            ch = $urandom_range(0, 9);
            if (ch == 0) r = 24'd0;
            else if (ch <= 3) r = 24'($urandom & $urandom & $urandom);
            else if (ch == 4) r = r & ~(24'd1 << $urandom_range(0, 23));
            c = ($urandom_range(0, 39) != 0);
            step(r, c);
            for (int k = 0; k < 2; k++) begin
                eg = 24'd0;
                if (m_own[k] >= 0) eg[m_own[k]] = 1'b1;
                n_checks++;
                if (grant_w[k] !== eg || sel_w[k] !== 5'((m_own[k] < 0) ? 0 : m_own[k]) ||
                    valid_w[k] !== (m_own[k] >= 0) || pre_w[k] !== m_pre[k]) begin
                    n_errors++;
                    $display("FAIL random dut%0d cycle %0d: grant=%h sel=%0d valid=%b pre=%b, required grant=%h owner=%0d pre=%b",
                             k, i, grant_w[k], sel_w[k], valid_w[k], pre_w[k], eg, m_own[k], m_pre[k]);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_max[0] = 4;
        m_max[1] = 1;
        for (int k = 0; k < 2; k++) begin
            m_own[k]  = -1;
            m_ptr[k]  = 0;
            m_hold[k] = 0;
            m_pre[k]  = 1'b0;
        end
        req   = 24'd0;
        clear = 1'b0;
        test_reset();
        test_basic();
        test_hold_preempt();
        test_wrap();
        test_all_max1();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 4, max consecutive grant cycles for one source while others wait; legal range 1..15.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 clear  input  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-004 req  input  24  level request per bus source; bit i = mux select code i (0-15 R0-R15, 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR, 22 InPort, 23 C).
REQ-005 Select  output  5  registered bus mux select code of current owner; drives the 32-to-1 bus mux select.
REQ-006 grant  output  24  registered one-hot grant; bit i set iff source i owns the bus.
REQ-007 bus_valid  output  1  registered; 1 when an owner exists, 0 when idle.
REQ-008 preempt  output  1  registered one-cycle pulse when an owner is forced off by hold-limit expiry.

Function
REQ-009 The block SHALL implement two states: IDLE (no owner) and OWNED (exactly one owner).
REQ-010 Arbitration SHALL be round-robin over 24 sources using a 5-bit priority pointer ptr (0..23); the winner is the first set req bit at index ptr, ptr+1, ..., wrapping 23->0.
REQ-011 On every grant to source w, ptr SHALL become w+1, with 23 wrapping to 0.
REQ-012 Latency: req sampled at edge N SHALL produce grant/Select/bus_valid at edge N+1; no combinational path from req to outputs.
REQ-013 IDLE, req==0: SHALL stay IDLE; Select=0, grant=0, bus_valid=0.
REQ-014 IDLE, req!=0: SHALL enter OWNED with the round-robin winner; hold_cnt cleared to 0.
REQ-015 OWNED, owner's req still 1, no other req set: SHALL keep owner; hold_cnt saturates at MAX_HOLD-1.
REQ-016 OWNED, owner's req still 1, other req set, hold_cnt < MAX_HOLD-1: SHALL keep owner and increment hold_cnt.
REQ-017 OWNED, owner's req still 1, other req set, hold_cnt == MAX_HOLD-1: SHALL grant next round-robin winner excluding current owner, clear hold_cnt, pulse preempt for one cycle.
REQ-018 OWNED, owner's req drops, other req set: SHALL hand over directly to the round-robin winner with no idle cycle; preempt stays 0.
REQ-019 OWNED, owner's req drops, no other req: SHALL return to IDLE next edge.
REQ-020 Owner drop and new requests in the same cycle SHALL be handled as REQ-018 using the sampled req vector.
REQ-021 MAX_HOLD=1 SHALL re-arbitrate every cycle whenever another source requests.
REQ-022 Select SHALL always equal the index of the set grant bit; Select SHALL never exceed 23; grant SHALL never have more than one bit set.
REQ-023 preempt SHALL be 0 in any cycle it is not set by REQ-017.

Reset
REQ-024 clear=0 at a rising edge SHALL force IDLE, Select=0, grant=0, bus_valid=0, preempt=0, ptr=0, hold_cnt=0, regardless of req or current owner.
REQ-025 Reset mid-ownership SHALL drop the grant at that edge; the first edge with clear=1 SHALL arbitrate from ptr=0.

Verification
REQ-026 Reset then req=0x000001 (R0) -> one edge later grant=0x000001, Select=0, bus_valid=1; req=0 -> next edge bus_valid=0, grant=0.
REQ-027 MAX_HOLD=4, req bits 20 (PC) and 21 (MDR) held from reset -> owner sequence 20,20,20,20,21,21,21,21,20...; preempt pulses at each switch.
REQ-028 Owner 23 (C) drops req while req bit 0 set -> next edge Select=0, bus_valid stays 1, preempt=0 (wrap-around, no idle gap).
REQ-029 req=0xFFFFFF held, MAX_HOLD=1 -> Select steps 0,1,...,23,0 each cycle; grant always one-hot.
REQ-030 Owner 19 (Zlow) active, clear=0 for one edge with req unchanged -> outputs zero that edge; next edge owner = first set bit from 0.
